axis_sniffer_capture_ctrl: RTL and testbench

- Sequences the monitor tap of the sniffer path.
- The main stream S->M passes through unchanged and is never stalled by the monitor side.
- On a start command, the block captures a decimated burst of LENGTH samples onto a registered monitor stream with tlast on the final sample, then reports done.
- Monitor backpressure causes dropped samples and a sticky overflow flag; it never stalls the datapath.

---
 rtl/axis_sniffer_capture_ctrl.sv | 176 +++++++++++++++++
 tb/tb_axis_sniffer_capture_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_sniffer_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : axis_sniffer_capture_ctrl
// Brief    : Passes the main AXI-Stream path through untouched and captures a
//            decimated, tlast-terminated burst onto a registered monitor stream.
// Revision : 1.0 - initial release
// ============================================================================
module axis_sniffer_capture_ctrl #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int COUNT_WIDTH      = 16
) (
    input  logic                        aclk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        abort,
    input  logic [COUNT_WIDTH-1:0]      length,
    input  logic [COUNT_WIDTH-1:0]      decimation,
    input  logic                        S_AXIS_tvalid,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    output logic                        S_AXIS_tready,
    input  logic                        M_AXIS_tready,
    output logic                        M_AXIS_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    input  logic                        MS_AXIS_tready,
    output logic                        MS_AXIS_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0] MS_AXIS_tdata,
    output logic                        MS_AXIS_tlast,
    output logic                        busy,
    output logic                        done,
    output logic                        overflow
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] c_zero = '0;
    localparam logic [COUNT_WIDTH-1:0] c_one  = COUNT_WIDTH'(1);

    state_t                      r_state;
    state_t                      w_state_next;
    logic [COUNT_WIDTH-1:0]      r_remaining;
    logic [COUNT_WIDTH-1:0]      r_dec_cnt;
    logic [COUNT_WIDTH-1:0]      r_dec_reload;
    logic                        r_ms_tvalid;
    logic                        r_ms_tlast;
    logic [AXIS_TDATA_WIDTH-1:0] r_ms_tdata;
    logic                        r_done;
    logic                        r_overflow;

    logic w_beat;
    logic w_free;
    logic w_slot;
    logic w_load;
    logic w_last_sample;
    logic w_ms_hs;

    // Main path is a pure wire-through; the monitor never throttles it.
    assign M_AXIS_tvalid = S_AXIS_tvalid;
    assign M_AXIS_tdata  = S_AXIS_tdata;
    assign S_AXIS_tready = M_AXIS_tready;

    assign w_beat        = S_AXIS_tvalid & M_AXIS_tready;
    assign w_free        = ~r_ms_tvalid | MS_AXIS_tready;
    assign w_ms_hs       = r_ms_tvalid & MS_AXIS_tready;
    assign w_slot        = (r_state == S_CAPTURE) & w_beat & (r_dec_cnt == c_zero);
    assign w_load        = w_slot & w_free;
    assign w_last_sample = (r_remaining == c_one);

    always_ff @(posedge aclk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (abort) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && (length != c_zero)) begin
                        w_state_next = S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (w_load && w_last_sample) begin
                        w_state_next = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_ms_hs && r_ms_tlast) begin
                        w_state_next = S_IDLE;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            r_remaining  <= '0;
            r_dec_cnt    <= '0;
            r_dec_reload <= '0;
            r_ms_tvalid  <= 1'b0;
            r_ms_tlast   <= 1'b0;
            r_ms_tdata   <= '0;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_ms_hs) begin
                r_ms_tvalid <= 1'b0;
                r_ms_tlast  <= 1'b0;
            end
            if (abort) begin
                // Held sample is discarded; overflow survives for inspection.
                r_ms_tvalid <= 1'b0;
                r_ms_tlast  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_overflow   <= 1'b0;
                            r_remaining  <= length;
                            r_dec_cnt    <= '0;
                            r_dec_reload <= (decimation == c_zero) ? c_zero : (decimation - c_one);
                            if (length == c_zero) begin
                                r_done <= 1'b1;
                            end
                        end
                    end
                    S_CAPTURE: begin
                        if (w_beat) begin
                            if (r_dec_cnt != c_zero) begin
                                r_dec_cnt <= r_dec_cnt - c_one;
                            end else begin
                                r_dec_cnt <= r_dec_reload;
                                if (w_free) begin
                                    r_ms_tdata  <= S_AXIS_tdata;
                                    r_ms_tvalid <= 1'b1;
                                    r_ms_tlast  <= w_last_sample;
                                    r_remaining <= r_remaining - c_one;
                                end else begin
                                    // Dropped slot: remaining untouched so the burst still delivers length samples.
                                    r_overflow <= 1'b1;
                                end
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (w_ms_hs && r_ms_tlast) begin
                            r_done <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign MS_AXIS_tvalid = r_ms_tvalid;
    assign MS_AXIS_tdata  = r_ms_tdata;
    assign MS_AXIS_tlast  = r_ms_tlast;
    assign busy           = (r_state != S_IDLE);
    assign done           = r_done;
    assign overflow       = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_axis_sniffer_capture_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_sniffer_capture_ctrl
// Brief    : Directed stimulus with a queue scoreboard for the monitor stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_sniffer_capture_ctrl;

    localparam int c_w  = 32;
    localparam int c_cw = 16;

    logic            aclk;
    logic            reset;
    logic            start;
    logic            abort;
    logic [c_cw-1:0] length;
    logic [c_cw-1:0] decimation;
    logic            S_AXIS_tvalid;
    logic [c_w-1:0]  S_AXIS_tdata;
    logic            S_AXIS_tready;
    logic            M_AXIS_tready;
    logic            M_AXIS_tvalid;
    logic [c_w-1:0]  M_AXIS_tdata;
    logic            MS_AXIS_tready;
    logic            MS_AXIS_tvalid;
    logic [c_w-1:0]  MS_AXIS_tdata;
    logic            MS_AXIS_tlast;
    logic            busy;
    logic            done;
    logic            overflow;

    typedef struct packed {
        logic [c_w-1:0] data;
        logic           last;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   done_cnt = 0;

    axis_sniffer_capture_ctrl #(
        .AXIS_TDATA_WIDTH (c_w),
        .COUNT_WIDTH      (c_cw)
    ) u_dut (
        .aclk           (aclk),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .length         (length),
        .decimation     (decimation),
        .S_AXIS_tvalid  (S_AXIS_tvalid),
        .S_AXIS_tdata   (S_AXIS_tdata),
        .S_AXIS_tready  (S_AXIS_tready),
        .M_AXIS_tready  (M_AXIS_tready),
        .M_AXIS_tvalid  (M_AXIS_tvalid),
        .M_AXIS_tdata   (M_AXIS_tdata),
        .MS_AXIS_tready (MS_AXIS_tready),
        .MS_AXIS_tvalid (MS_AXIS_tvalid),
        .MS_AXIS_tdata  (MS_AXIS_tdata),
        .MS_AXIS_tlast  (MS_AXIS_tlast),
        .busy           (busy),
        .done           (done),
        .overflow       (overflow)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic cycle();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [c_w-1:0] act, input logic [c_w-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push(input logic [c_w-1:0] d, input logic l);
        exp_t e;
        e.data = d;
        e.last = l;
        exp_q.push_back(e);
    endtask

    // Monitor: pops one expectation per monitor handshake; also tracks done pulses.
    always @(negedge aclk) begin
        if (!reset) begin
            if (MS_AXIS_tvalid && MS_AXIS_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL ms_unexpected: got data=%0d last=%0b, required no sample", MS_AXIS_tdata, MS_AXIS_tlast);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (MS_AXIS_tdata !== e.data || MS_AXIS_tlast !== e.last) begin
                        failures++;
                        $display("FAIL ms_sample: got data=%0d last=%0b, required data=%0d last=%0b",
                                 MS_AXIS_tdata, MS_AXIS_tlast, e.data, e.last);
                    end
                end
            end
            if (done) begin
                done_cnt++;
                checks++;
                if (busy !== 1'b0) begin
                    failures++;
                    $display("FAIL busy_at_done: got %0b, required 0", busy);
                end
            end
        end
    end

    logic [c_w-1:0] pt_data  [6] = '{32'h0000_0001, 32'hDEAD_BEEF, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0, 32'hA5A5_5A5A};
    logic           pt_valid [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic           pt_ready [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; length = '0; decimation = '0;
        S_AXIS_tvalid = 1'b0; S_AXIS_tdata = '0; M_AXIS_tready = 1'b0; MS_AXIS_tready = 1'b0;
        repeat (2) cycle();
        @(negedge aclk);
        chk("rst_ms_tvalid", {31'b0, MS_AXIS_tvalid}, 0);
        chk("rst_ms_tlast",  {31'b0, MS_AXIS_tlast},  0);
        chk("rst_ms_tdata",  MS_AXIS_tdata, 0);
        chk("rst_busy",      {31'b0, busy},     0);
        chk("rst_done",      {31'b0, done},     0);
        chk("rst_overflow",  {31'b0, overflow}, 0);
        cycle();
        reset = 1'b0;

        // Passthrough while idle
        for (int i = 0; i < 6; i++) begin
            S_AXIS_tvalid = pt_valid[i]; S_AXIS_tdata = pt_data[i];
            M_AXIS_tready = pt_ready[i]; MS_AXIS_tready = (i % 2 == 0);
            @(negedge aclk);
            chk("pt_m_tvalid",  {31'b0, M_AXIS_tvalid},  {31'b0, pt_valid[i]});
            chk("pt_m_tdata",   M_AXIS_tdata, pt_data[i]);
            chk("pt_s_tready",  {31'b0, S_AXIS_tready},  {31'b0, pt_ready[i]});
            chk("pt_ms_tvalid", {31'b0, MS_AXIS_tvalid}, 0);
            cycle();
        end

        // Basic burst: length 4, decimation 1
        S_AXIS_tvalid = 1'b0; M_AXIS_tready = 1'b1; MS_AXIS_tready = 1'b1;
        start = 1'b1; length = 16'd4; decimation = 16'd1;
        cycle();
        start = 1'b0; length = 16'd9; decimation = 16'd3;
        push(10, 0); push(11, 0); push(12, 0); push(13, 1);
        for (int i = 0; i < 7; i++) begin
            S_AXIS_tvalid = 1'b1; S_AXIS_tdata = 10 + i;
            if (i == 0) begin
                @(negedge aclk);
                chk("basic_busy", {31'b0, busy}, 1);
            end
            cycle();
        end
        S_AXIS_tvalid = 1'b0;
        repeat (2) cycle();
        @(negedge aclk);
        chk("basic_done_cnt", done_cnt, 1);

        // Decimation: length 3, every 4th beat
        start = 1'b1; length = 16'd3; decimation = 16'd4;
        cycle();
        start = 1'b0;
        push(0, 0); push(4, 0); push(8, 1);
        for (int i = 0; i < 12; i++) begin
            S_AXIS_tvalid = 1'b1; S_AXIS_tdata = i;
            cycle();
        end
        S_AXIS_tvalid = 1'b0;
        repeat (3) cycle();
        @(negedge aclk);
        chk("dec_overflow", {31'b0, overflow}, 0);
        chk("dec_done_cnt", done_cnt, 2);

        // Backpressure: first sample held, next two slots dropped
        start = 1'b1; length = 16'd3; decimation = 16'd1;
        cycle();
        start = 1'b0;
        push(20, 0); push(23, 0); push(24, 1);
        S_AXIS_tvalid = 1'b1; S_AXIS_tdata = 20; MS_AXIS_tready = 1'b0;
        cycle();
        S_AXIS_tdata = 21;
        @(negedge aclk);
        chk("bp_hold_valid1", {31'b0, MS_AXIS_tvalid}, 1);
        chk("bp_hold_data1",  MS_AXIS_tdata, 20);
        cycle();
        S_AXIS_tdata = 22;
        @(negedge aclk);
        chk("bp_hold_data2",  MS_AXIS_tdata, 20);
        cycle();
        S_AXIS_tdata = 23; MS_AXIS_tready = 1'b1;
        cycle();
        S_AXIS_tdata = 24;
        cycle();
        S_AXIS_tvalid = 1'b0;
        repeat (3) cycle();
        @(negedge aclk);
        chk("bp_overflow", {31'b0, overflow}, 1);
        chk("bp_done_cnt", done_cnt, 3);

        // Abort mid-capture, then zero-length start
        start = 1'b1; length = 16'd8; decimation = 16'd1;
        cycle();
        start = 1'b0;
        @(negedge aclk);
        chk("ab_ovf_cleared", {31'b0, overflow}, 0);
        push(30, 0);
        S_AXIS_tvalid = 1'b1; S_AXIS_tdata = 30;
        cycle();
        S_AXIS_tdata = 31;
        cycle();
        S_AXIS_tdata = 32; MS_AXIS_tready = 1'b0;
        cycle();
        S_AXIS_tvalid = 1'b0; abort = 1'b1;
        cycle();
        abort = 1'b0;
        @(negedge aclk);
        chk("ab_ms_tvalid", {31'b0, MS_AXIS_tvalid}, 0);
        chk("ab_ms_tlast",  {31'b0, MS_AXIS_tlast},  0);
        chk("ab_busy",      {31'b0, busy},     0);
        chk("ab_overflow",  {31'b0, overflow}, 1);
        repeat (3) cycle();
        @(negedge aclk);
        chk("ab_no_done", done_cnt, 3);
        start = 1'b1; length = 16'd0; decimation = 16'd0;
        cycle();
        start = 1'b0;
        @(negedge aclk);
        chk("zl_done",  {31'b0, done}, 1);
        chk("zl_busy",  {31'b0, busy}, 0);
        cycle();
        @(negedge aclk);
        chk("zl_done_once", {31'b0, done}, 0);
        chk("zl_done_cnt", done_cnt, 4);

        // Start while busy must not reload counters
        MS_AXIS_tready = 1'b1;
        start = 1'b1; length = 16'd3; decimation = 16'd1;
        cycle();
        start = 1'b0;
        push(50, 0); push(51, 0); push(52, 1);
        S_AXIS_tvalid = 1'b1; S_AXIS_tdata = 50;
        cycle();
        S_AXIS_tdata = 51; start = 1'b1; length = 16'd1;
        cycle();
        start = 1'b0; S_AXIS_tdata = 52;
        cycle();
        S_AXIS_tvalid = 1'b0;
        repeat (3) cycle();
        @(negedge aclk);
        chk("ign_done_cnt", done_cnt, 5);

        // Reset while draining with monitor stalled
        start = 1'b1; length = 16'd2; decimation = 16'd1; MS_AXIS_tready = 1'b0;
        cycle();
        start = 1'b0;
        push(40, 0);
        S_AXIS_tvalid = 1'b1; S_AXIS_tdata = 40;
        cycle();
        S_AXIS_tdata = 41;
        cycle();
        S_AXIS_tdata = 42; MS_AXIS_tready = 1'b1;
        cycle();
        MS_AXIS_tready = 1'b0; S_AXIS_tvalid = 1'b0; S_AXIS_tdata = '0; M_AXIS_tready = 1'b0;
        @(negedge aclk);
        chk("dr_busy",     {31'b0, busy},          1);
        chk("dr_ms_tlast", {31'b0, MS_AXIS_tlast}, 1);
        chk("dr_ms_tdata", MS_AXIS_tdata, 42);
        chk("dr_overflow", {31'b0, overflow},      1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        @(negedge aclk);
        chk("rr_ms_tvalid", {31'b0, MS_AXIS_tvalid}, 0);
        chk("rr_ms_tlast",  {31'b0, MS_AXIS_tlast},  0);
        chk("rr_ms_tdata",  MS_AXIS_tdata, 0);
        chk("rr_busy",      {31'b0, busy},     0);
        chk("rr_done",      {31'b0, done},     0);
        chk("rr_overflow",  {31'b0, overflow}, 0);
        chk("rr_m_tvalid",  {31'b0, M_AXIS_tvalid}, 0);
        repeat (2) cycle();
        @(negedge aclk);
        chk("rr_done_cnt", done_cnt, 5);
        chk("exp_q_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
